step_pulse: RTL and testbench

- Consumer-side companion to the slow-clock divider: turns a slow, bouncy external level (push-button or slow clock pin) into clean single-cycle enable pulses in the osc_clk domain.
- The multiplier datapath steps on these enables instead of running off a derived clock.
- Contents: 2-flop synchroniser, debounce FSM, optional auto-repeat while the input is held.
- Sits between board pins and the multiplier control FSM.

---
 rtl/step_pkg.sv | 16 +
 rtl/sync_ff.sv | 22 ++
 rtl/step_pulse.sv | 102 ++++++++++
 tb/tb_step_pulse.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types for the step_pulse debouncer.
// Holds the debounce FSM state encoding and the level lookup.
package step_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } step_state_t;

   function automatic logic state_level(step_state_t s);
      return (s == HELD) || (s == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchroniser with synchronous reset.
// Brings one asynchronous pin into the osc_clk domain.
module sync_ff (
   input  logic osc_clk,
   input  logic reset,
   input  logic async_bit,
   output logic sync_bit
);

   logic sync1;

   always_ff @(posedge osc_clk) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync_bit <= 1'b0;
      end else begin
         sync1    <= async_bit;
         sync_bit <= sync1;
      end
   end

endmodule

// File: rtl/step_pulse.sv
// Debounces a slow bouncy level into single-cycle step enables,
// with optional auto-repeat while the input stays held.
module step_pulse
   import step_pkg::*;
#(
   parameter int unsigned DB_BITS     = 16,
   parameter int unsigned REPEAT_BITS = 20,
   parameter bit          REPEAT_EN   = 1'b1
) (
   input  logic osc_clk,
   input  logic reset,
   input  logic raw_in,
   output logic step,
   output logic level
);

   localparam logic [DB_BITS-1:0] DB_MAX = '1;

   step_state_t            state;
   step_state_t            state_nx;
   logic [DB_BITS-1:0]     db_cnt;
   logic [DB_BITS-1:0]     db_cnt_nx;
   logic [REPEAT_BITS-1:0] rep_cnt;
   logic [REPEAT_BITS-1:0] rep_cnt_nx;
   logic                   step_nx;
   logic                   sync2;

   sync_ff u_sync (
      .osc_clk   (osc_clk),
      .reset     (reset),
      .async_bit (raw_in),
      .sync_bit  (sync2)
   );

   always_ff @(posedge osc_clk) begin
      if (reset) begin
         state   <= IDLE;
         db_cnt  <= '0;
         rep_cnt <= '0;
         step    <= 1'b0;
         level   <= 1'b0;
      end else begin
         state   <= state_nx;
         db_cnt  <= db_cnt_nx;
         rep_cnt <= rep_cnt_nx;
         step    <= step_nx;
         // Registered alongside state so it always matches it.
         level   <= state_level(state_nx);
      end
   end

   always_comb begin
      state_nx   = state;
      db_cnt_nx  = db_cnt;
      rep_cnt_nx = rep_cnt;
      step_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync2) begin
               state_nx  = PRESS_WAIT;
               db_cnt_nx = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync2) begin
               state_nx = IDLE;
            end else if (db_cnt == DB_MAX) begin
               state_nx   = HELD;
               step_nx    = 1'b1;
               rep_cnt_nx = '0;
            end else begin
               db_cnt_nx = db_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!sync2) begin
               state_nx  = RELEASE_WAIT;
               db_cnt_nx = '0;
            end else begin
               // Wraps on purpose to pace the repeat pulses.
               rep_cnt_nx = rep_cnt + 1'b1;
               if (REPEAT_EN && (&rep_cnt)) begin
                  step_nx = 1'b1;
               end
            end
         end
         RELEASE_WAIT: begin
            if (sync2) begin
               state_nx = HELD;
            end else if (db_cnt == DB_MAX) begin
               state_nx = IDLE;
            end else begin
               db_cnt_nx = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_step_pulse.sv
// Scoreboard bench for step_pulse: run-length reference model,
// one repeating and one single-shot instance on the same input.
module tb_step_pulse;

   localparam int DB  = 3;
   localparam int RB  = 5;
   localparam int DBN = 2 ** DB;
   localparam int RBN = 2 ** RB;

   typedef struct packed {
      logic stp;
      logic lvl;
   } exp_t;

   logic osc_clk;
   logic reset;
   logic raw_in;
   logic step_rep;
   logic level_rep;
   logic step_one;
   logic level_one;

   int vectors;
   int miscompares;
   int cyc;

   exp_t q_rep[$];
   exp_t q_one[$];

   logic win_on;
   int   win_id;
   int   win_exp_rep;
   int   win_exp_one;

   step_pulse #(
      .DB_BITS     (DB),
      .REPEAT_BITS (RB),
      .REPEAT_EN   (1'b1)
   ) u_rep (
      .osc_clk (osc_clk),
      .reset   (reset),
      .raw_in  (raw_in),
      .step    (step_rep),
      .level   (level_rep)
   );

   step_pulse #(
      .DB_BITS     (DB),
      .REPEAT_BITS (RB),
      .REPEAT_EN   (1'b0)
   ) u_one (
      .osc_clk (osc_clk),
      .reset   (reset),
      .raw_in  (raw_in),
      .step    (step_one),
      .level   (level_one)
   );

   initial osc_clk = 1'b0;
   always #5 osc_clk = ~osc_clk;

   // Reference: a press/release is accepted once the synchronised
   // input has held its new value for DBN+1 consecutive samples.
   logic m_s1;
   logic m_s2;
   logic m_d[2];
   int   m_hi[2];
   int   m_lo[2];
   int   m_rc[2];

   always @(posedge osc_clk) begin
      logic s;
      exp_t e[2];
      cyc = cyc + 1;
      if (reset) begin
         m_s1 = 1'b0;
         m_s2 = 1'b0;
         for (int m = 0; m < 2; m++) begin
            m_d[m]  = 1'b0;
            m_hi[m] = 0;
            m_lo[m] = 0;
            m_rc[m] = 0;
            e[m]    = '0;
         end
      end else begin
         s    = m_s2;
         m_s2 = m_s1;
         m_s1 = raw_in;
         for (int m = 0; m < 2; m++) begin
            e[m].stp = 1'b0;
            if (!m_d[m]) begin
               m_hi[m] = s ? m_hi[m] + 1 : 0;
               if (m_hi[m] == DBN + 1) begin
                  m_d[m]   = 1'b1;
                  e[m].stp = 1'b1;
                  m_hi[m]  = 0;
                  m_lo[m]  = 0;
                  m_rc[m]  = 0;
               end
            end else if (!s) begin
               m_lo[m] = m_lo[m] + 1;
               if (m_lo[m] == DBN + 1) begin
                  m_d[m]  = 1'b0;
                  m_lo[m] = 0;
                  m_hi[m] = 0;
               end
            end else if (m_lo[m] != 0) begin
               m_lo[m] = 0;
            end else begin
               m_rc[m] = (m_rc[m] + 1) % RBN;
               if (m == 0 && m_rc[m] == 0) e[m].stp = 1'b1;
            end
            e[m].lvl = m_d[m];
         end
      end
      q_rep.push_back(e[0]);
      q_one.push_back(e[1]);
   end

   // Monitor: pops one expectation per cycle and tallies windows.
   int   cnt_rep;
   int   cnt_one;
   logic win_was;

   initial begin
      cnt_rep = 0;
      cnt_one = 0;
      win_was = 1'b0;
   end

   always begin
      exp_t e;
      @(posedge osc_clk);
      #2;
      if (q_rep.size() > 0) begin
         e = q_rep.pop_front();
         vectors = vectors + 1;
         if ({step_rep, level_rep} !== {e.stp, e.lvl}) begin
            miscompares = miscompares + 1;
            $display("FAIL rep_out cyc=%0d got step=%b level=%b exp step=%b level=%b",
                     cyc, step_rep, level_rep, e.stp, e.lvl);
         end
      end
      if (q_one.size() > 0) begin
         e = q_one.pop_front();
         vectors = vectors + 1;
         if ({step_one, level_one} !== {e.stp, e.lvl}) begin
            miscompares = miscompares + 1;
            $display("FAIL one_out cyc=%0d got step=%b level=%b exp step=%b level=%b",
                     cyc, step_one, level_one, e.stp, e.lvl);
         end
      end
      if (win_on) begin
         cnt_rep = cnt_rep + int'(step_rep);
         cnt_one = cnt_one + int'(step_one);
         win_was = 1'b1;
      end else if (win_was) begin
         vectors = vectors + 2;
         if (cnt_rep != win_exp_rep) begin
            miscompares = miscompares + 1;
            $display("FAIL win%0d_rep_steps got %0d exp %0d",
                     win_id, cnt_rep, win_exp_rep);
         end
         if (cnt_one != win_exp_one) begin
            miscompares = miscompares + 1;
            $display("FAIL win%0d_one_steps got %0d exp %0d",
                     win_id, cnt_one, win_exp_one);
         end
         cnt_rep = 0;
         cnt_one = 0;
         win_was = 1'b0;
      end
   end

   task automatic hold(input logic v, input int n);
      raw_in = v;
      repeat (n) @(negedge osc_clk);
   endtask

   task automatic open_win(input int id, input int er, input int eo);
      win_id      = id;
      win_exp_rep = er;
      win_exp_one = eo;
      win_on      = 1'b1;
   endtask

   task automatic close_win();
      win_on = 1'b0;
      hold(1'b0, 3);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      win_on      = 1'b0;
      win_id      = 0;
      win_exp_rep = 0;
      win_exp_one = 0;
      reset       = 1'b1;
      raw_in      = 1'b1;
      @(negedge osc_clk);
      hold(1'b1, 3);
      reset = 1'b0;

      open_win(1, 1, 1);
      hold(1'b1, 30);
      hold(1'b0, 20);
      close_win();

      open_win(2, 3, 1);
      hold(1'b1, 100);
      hold(1'b0, 20);
      close_win();

      open_win(3, 1, 1);
      hold(1'b1, 5);
      hold(1'b0, 1);
      hold(1'b1, 20);
      hold(1'b0, 20);
      close_win();

      open_win(4, 1, 1);
      hold(1'b1, 30);
      hold(1'b0, 4);
      hold(1'b1, 5);
      hold(1'b0, 20);
      close_win();

      hold(1'b1, 20);
      reset = 1'b1;
      hold(1'b1, 2);
      reset = 1'b0;
      open_win(5, 1, 1);
      hold(1'b1, 20);
      hold(1'b0, 20);
      close_win();

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            reset = 1'b1;
            hold(raw_in, int'($urandom_range(1, 2)));
            reset = 1'b0;
         end
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
      end

      hold(1'b0, 5);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
